// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : arm_mem_pkg
// Brief    : Shared encodings and default widths for the RAM arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

   localparam int c_addr_w = 32;
   localparam int c_data_w = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } phase_t;

   typedef enum logic [0:0] {
      OWN_LD  = 1'b0,
      OWN_ARM = 1'b1
   } owner_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : ram_arbiter_if
// Brief     : Loader, core and basic_ram buses around the RAM arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              ld_finished;
   logic              cpu_rst;

   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_cs;
   logic              ld_we;
   logic              ld_oe;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_done;

   logic [ADDR_W-1:0] arm_addr;
   logic [DATA_W-1:0] arm_wdata;
   logic              arm_cs;
   logic              arm_we;
   logic              arm_oe;
   logic [DATA_W-1:0] arm_rdata;
   logic              arm_done;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_cs;
   logic              ram_we;
   logic              ram_oe;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_mem_done;

   logic              err;

   // Arbiter view: it masters basic_ram and serves both requesters.
   modport master (
      input  ld_finished,
      input  ld_addr, ld_wdata, ld_cs, ld_we, ld_oe,
      input  arm_addr, arm_wdata, arm_cs, arm_we, arm_oe,
      input  ram_rdata, ram_mem_done,
      output cpu_rst,
      output ld_rdata, ld_done,
      output arm_rdata, arm_done,
      output ram_addr, ram_wdata, ram_cs, ram_we, ram_oe,
      output err
   );

   modport slave (
      output ld_finished,
      output ld_addr, ld_wdata, ld_cs, ld_we, ld_oe,
      output arm_addr, arm_wdata, arm_cs, arm_we, arm_oe,
      output ram_rdata, ram_mem_done,
      input  cpu_rst,
      input  ld_rdata, ld_done,
      input  arm_rdata, arm_done,
      input  ram_addr, ram_wdata, ram_cs, ram_we, ram_oe,
      input  err
   );

endinterface
`default_nettype wire

// File: rtl/ram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rr2
// Brief    : Combinational two-way round-robin pick between LD and ARM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rr2
   import arm_mem_pkg::*;
(
   input  owner_t     i_last_grant,
   input  logic [1:0] i_req,        // bit 0 = LD, bit 1 = ARM
   output logic       o_vld,
   output owner_t     o_pick
);

   always_comb begin
      o_vld  = |i_req;
      o_pick = OWN_LD;
      if (i_req == 2'b11) begin
         // Contention: whoever was not served last goes first.
         o_pick = (i_last_grant == OWN_LD) ? OWN_ARM : OWN_LD;
      end else if (i_req[1]) begin
         o_pick = OWN_ARM;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares basic_ram between loader and ARMv4 core; sequences boot.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W   = c_addr_w,
   parameter int DATA_W   = c_data_w,
   parameter int RST_HOLD = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.master bus
);

   localparam int c_TMO_W  = $clog2(TIMEOUT + 1);
   localparam int c_HOLD_W = $clog2(RST_HOLD + 1);

   state_t              r_state;
   phase_t              r_phase;
   owner_t              r_owner;
   owner_t              r_last_grant;
   logic                r_cpu_rst;
   logic                r_ld_done;
   logic                r_arm_done;
   logic                r_err;
   logic [DATA_W-1:0]   r_ld_rdata;
   logic [DATA_W-1:0]   r_arm_rdata;
   logic [c_TMO_W-1:0]  r_tmo_cnt;
   logic                r_hold_act;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                r_fin_seen;

   logic                w_ld_req;
   logic                w_arm_req;
   logic [1:0]          w_elig;
   logic                w_grant_vld;
   owner_t              w_pick;
   logic                w_own_cs;
   logic                w_own_we;
   logic                w_own_oe;
   logic [ADDR_W-1:0]   w_own_addr;
   logic [DATA_W-1:0]   w_own_wdata;
   logic                w_own_rd;
   logic                w_ram_cs;
   logic                w_ram_we;
   logic                w_ram_oe;

   assign w_ld_req  = bus.ld_cs  & (bus.ld_we  | bus.ld_oe);
   assign w_arm_req = bus.arm_cs & (bus.arm_we | bus.arm_oe);
   // The core stays invisible to the arbiter until boot has released it.
   assign w_elig    = {w_arm_req & (r_phase == RUN), w_ld_req};

   ram_arb_rr2 u_rr2 (
      .i_last_grant (r_last_grant),
      .i_req        (w_elig),
      .o_vld        (w_grant_vld),
      .o_pick       (w_pick)
   );

   assign w_own_cs    = (r_owner == OWN_ARM) ? bus.arm_cs    : bus.ld_cs;
   assign w_own_we    = (r_owner == OWN_ARM) ? bus.arm_we    : bus.ld_we;
   assign w_own_oe    = (r_owner == OWN_ARM) ? bus.arm_oe    : bus.ld_oe;
   assign w_own_addr  = (r_owner == OWN_ARM) ? bus.arm_addr  : bus.ld_addr;
   assign w_own_wdata = (r_owner == OWN_ARM) ? bus.arm_wdata : bus.ld_wdata;
   assign w_own_rd    = w_own_oe & ~w_own_we;

   always_comb begin
      w_ram_cs = 1'b0;
      w_ram_we = 1'b0;
      w_ram_oe = 1'b0;
      if (r_state == SERVE) begin
         w_ram_cs = w_own_cs;
         w_ram_we = w_own_cs & w_own_we;
         w_ram_oe = w_own_cs & w_own_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_phase      <= BOOT;
         r_owner      <= OWN_LD;
         r_last_grant <= OWN_ARM;
         r_cpu_rst    <= 1'b1;
         r_ld_done    <= 1'b0;
         r_arm_done   <= 1'b0;
         r_err        <= 1'b0;
         r_ld_rdata   <= '0;
         r_arm_rdata  <= '0;
         r_tmo_cnt    <= '0;
         r_hold_act   <= 1'b0;
         r_hold_cnt   <= '0;
         r_fin_seen   <= 1'b0;
      end else begin
         r_ld_done  <= 1'b0;
         r_arm_done <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_grant_vld) begin
                  r_owner   <= w_pick;
                  r_state   <= SERVE;
                  r_tmo_cnt <= '0;
               end
            end
            SERVE: begin
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
               if (!w_own_cs) begin
                  r_state <= IDLE;
               end else if (bus.ram_mem_done) begin
                  r_state      <= IDLE;
                  r_last_grant <= r_owner;
                  if (r_owner == OWN_ARM) begin
                     r_arm_done <= 1'b1;
                     if (w_own_rd) r_arm_rdata <= bus.ram_rdata;
                  end else begin
                     r_ld_done <= 1'b1;
                     if (w_own_rd) r_ld_rdata <= bus.ram_rdata;
                  end
               end else if (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1)) begin
                  // TIMEOUT full SERVE cycles without mem_done: give up.
                  r_state <= IDLE;
                  r_err   <= 1'b1;
                  if (r_owner == OWN_ARM) r_arm_done <= 1'b1;
                  else                    r_ld_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase

         // A finish seen mid-transaction is remembered until the bus goes idle.
         if (r_phase == BOOT) begin
            if (bus.ld_finished) r_fin_seen <= 1'b1;
            if (r_hold_act) begin
               if (r_hold_cnt == c_HOLD_W'(RST_HOLD - 1)) begin
                  r_phase    <= RUN;
                  r_cpu_rst  <= 1'b0;
                  r_hold_act <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end else if (r_state == IDLE && (bus.ld_finished || r_fin_seen)) begin
               r_hold_act <= 1'b1;
               r_hold_cnt <= '0;
            end
         end
      end
   end

   assign bus.cpu_rst   = r_cpu_rst;
   assign bus.ld_rdata  = r_ld_rdata;
   assign bus.ld_done   = r_ld_done;
   assign bus.arm_rdata = r_arm_rdata;
   assign bus.arm_done  = r_arm_done;
   assign bus.err       = r_err;
   assign bus.ram_addr  = w_own_addr;
   assign bus.ram_wdata = w_own_wdata;
   assign bus.ram_cs    = w_ram_cs;
   assign bus.ram_we    = w_ram_we;
   assign bus.ram_oe    = w_ram_oe;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Self-checking bench for ram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int c_TIMEOUT  = 64;
   localparam int c_RST_HOLD = 4;

   logic clk;
   logic rst;

   ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ram_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RST_HOLD (c_RST_HOLD),
      .TIMEOUT  (c_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Behavioural RAM: answers after ram_lat SERVE cycles, never when 0.
   int          ram_lat = 1;
   int          ram_cnt = 0;
   logic [31:0] ram_mem [logic [31:0]];

   // Reference model state.
   logic [31:0] exp_mem [logic [31:0]];
   logic [31:0] exp_ld_rdata  = 32'h0;
   logic [31:0] exp_arm_rdata = 32'h0;
   logic        exp_err       = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      bus.ram_mem_done = 1'b0;
      bus.ram_rdata    = 32'h0;
      forever begin
         @(negedge clk);
         if (rst || !bus.ram_cs) begin
            ram_cnt          = 0;
            bus.ram_mem_done = 1'b0;
            bus.ram_rdata    = $urandom;
         end else begin
            ram_cnt++;
            if (ram_lat != 0 && ram_cnt == ram_lat) begin
               bus.ram_mem_done = 1'b1;
               if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
               else bus.ram_rdata = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : 32'h0;
            end else begin
               bus.ram_mem_done = 1'b0;
               bus.ram_rdata    = $urandom;
            end
         end
      end
   end

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit is_arm, input logic cs, input logic we, input logic oe,
                        input logic [31:0] a, input logic [31:0] d);
      if (is_arm) begin
         bus.arm_cs = cs; bus.arm_we = we; bus.arm_oe = oe; bus.arm_addr = a; bus.arm_wdata = d;
      end else begin
         bus.ld_cs = cs; bus.ld_we = we; bus.ld_oe = oe; bus.ld_addr = a; bus.ld_wdata = d;
      end
   endtask

   // Request already driven; expects the grant grant_exp steps later and done
   // after the RAM latency (or c_TIMEOUT SERVE cycles when lat is 0).
   task automatic await_done(input bit is_arm, input bit we, input bit oe,
                             input logic [31:0] a, input logic [31:0] d,
                             input int lat, input int grant_exp);
      int eff, gstep, dstep;
      bit other;
      eff   = (lat == 0) ? c_TIMEOUT : lat;
      gstep = 0;
      dstep = 0;
      other = 1'b0;
      for (int n = 1; n <= grant_exp + eff + 4; n++) begin
         step();
         if (gstep == 0 && bus.ram_cs) begin
            gstep = n;
            check("ram_we", bus.ram_we, we);
            check("ram_oe", bus.ram_oe, oe & ~we);
            check("ram_addr", bus.ram_addr, a);
            if (we) check("ram_wdata", bus.ram_wdata, d);
         end
         if (is_arm ? bus.ld_done : bus.arm_done) other = 1'b1;
         if (is_arm ? bus.arm_done : bus.ld_done) begin
            dstep = n;
            break;
         end
      end
      drive(is_arm, 1'b0, 1'b0, 1'b0, a, d);
      check("grant_latency", gstep, grant_exp);
      check("done_latency", dstep, grant_exp + eff);
      check("other_done_quiet", other, 1'b0);
      if (lat == 0)      exp_err = 1'b1;
      else if (we)       exp_mem[a] = d;
      else if (is_arm)   exp_arm_rdata = mem_rd(a);
      else               exp_ld_rdata  = mem_rd(a);
      check("ld_rdata", bus.ld_rdata, exp_ld_rdata);
      check("arm_rdata", bus.arm_rdata, exp_arm_rdata);
      check("err", bus.err, exp_err);
      step();
      check("done_one_cycle", is_arm ? bus.arm_done : bus.ld_done, 1'b0);
   endtask

   initial begin
      bit          isa, we, oe, other;
      int          lat, k, ngr, nld, narm, low;
      bit          prev_cs;
      bit          owner_seq [4];
      logic [31:0] a, d;

      rst = 1'b1;
      bus.ld_finished = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      check("rst_cpu_rst", bus.cpu_rst, 1'b1);
      check("rst_ld_done", bus.ld_done, 1'b0);
      check("rst_arm_done", bus.arm_done, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_ram_ctl", {bus.ram_cs, bus.ram_we, bus.ram_oe}, 3'b000);
      check("rst_ld_rdata", bus.ld_rdata, 32'h0);
      check("rst_arm_rdata", bus.arm_rdata, 32'h0);
      rst = 1'b0;

      // Loader write during boot.
      ram_lat = 3;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      await_done(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3, 1);
      check("boot_cpu_rst", bus.cpu_rst, 1'b1);

      // Boot release: core request waits out the reset hold.
      ram_lat = 2;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      bus.ld_finished = 1'b1;
      for (int i = 1; i <= c_RST_HOLD + 1; i++) begin
         step();
         bus.ld_finished = 1'b0;
         check("hold_cpu_rst", bus.cpu_rst, i <= c_RST_HOLD);
         check("hold_no_grant", bus.ram_cs, 1'b0);
      end
      await_done(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2, 1);
      check("boot_arm_rdata", bus.arm_rdata, 32'hDEADBEEF);
      check("run_cpu_rst", bus.cpu_rst, 1'b0);

      // Randomised single-requester traffic in RUN.
      for (int i = 0; i < 20; i++) begin
         isa = 1'($urandom_range(0, 1));
         k   = $urandom_range(0, 2);
         we  = (k != 1);
         oe  = (k != 0);
         a   = 32'h100 + 32'($urandom_range(0, 3)) * 4;
         d   = $urandom;
         lat = $urandom_range(1, 5);
         ram_lat = lat;
         drive(isa, 1'b1, we, oe, a, d);
         await_done(isa, we, oe, a, d, lat, 1);
      end

      // Contention after an LD completion: ARM first, then strict alternation.
      ram_lat = 2;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
      await_done(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 2, 1);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0);
      ngr = 0; nld = 0; narm = 0; low = 0; prev_cs = 1'b0;
      for (int n = 0; n < 60 && (nld + narm) < 4; n++) begin
         step();
         if (bus.ld_done)  nld++;
         if (bus.arm_done) narm++;
         if (bus.ram_cs && !prev_cs) begin
            if (ngr > 0) check("rr_idle_gap", low, 1);
            if (ngr < 4) owner_seq[ngr] = (bus.ram_addr == 32'h108);
            ngr++;
         end
         low     = bus.ram_cs ? 0 : low + 1;
         prev_cs = bus.ram_cs;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("rr_grant_count", ngr, 4);
      for (int i = 0; i < 4; i++) check("rr_grant_owner", owner_seq[i], (i % 2) == 0);
      check("rr_ld_dones", nld, 2);
      check("rr_arm_dones", narm, 2);
      exp_ld_rdata  = mem_rd(32'h100);
      exp_arm_rdata = mem_rd(32'h108);
      check("rr_ld_rdata", bus.ld_rdata, exp_ld_rdata);
      check("rr_arm_rdata", bus.arm_rdata, exp_arm_rdata);
      step();
      check("rr_idle_after", bus.ram_cs, 1'b0);

      // Timeout on a core read.
      ram_lat = 0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
      await_done(1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 0, 1);
      step();
      check("err_sticky", bus.err, 1'b1);

      // Abort by dropping cs, then a we/oe conflict request.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h0);
      step();
      check("abort_grant", bus.ram_cs, 1'b1);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0);
      step();
      check("abort_no_done", bus.arm_done, 1'b0);
      check("abort_ram_cs", bus.ram_cs, 1'b0);
      check("abort_rdata", bus.arm_rdata, exp_arm_rdata);
      ram_lat = 3;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h10C, 32'hCAFEF00D);
      await_done(1'b1, 1'b1, 1'b1, 32'h10C, 32'hCAFEF00D, 3, 1);
      ram_lat = 1;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0);
      await_done(1'b0, 1'b0, 1'b1, 32'h10C, 32'h0, 1, 1);

      // Reset in the middle of an LD transaction.
      ram_lat = 0;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h110, 32'h12345678);
      step();
      check("midrst_grant", bus.ram_cs, 1'b1);
      step();
      rst = 1'b1;
      step();
      check("midrst_ram_cs", bus.ram_cs, 1'b0);
      check("midrst_cpu_rst", bus.cpu_rst, 1'b1);
      check("midrst_err", bus.err, 1'b0);
      check("midrst_rdata", {bus.ld_rdata, bus.arm_rdata}, 64'h0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      other = bus.ld_done;
      repeat (4) begin
         step();
         other = other | bus.ld_done;
      end
      check("midrst_no_done", other, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
